pipeline_stall_controller: RTL
==============================

# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the raw hazard indications from hazard detection (load-use, branch operand dependency) with the interlock for the background multi-cycle multiply/divide unit. It also tracks the branch-after-load two-cycle stall as an explicit state. It drives the PC and IF/ID write enables, the IF/ID flush and the ID/EX bubble select, and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- MD_LATENCY, 32, cycles a mult/div occupies HI/LO after entering EX (legal range 2..255)
- CNT_W, 16, width of each performance counter

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous active-low reset
- ld_use  input  1  ID/EX is a load and its rt matches IF/ID rs or rt
- br_dep_alu  input  1  branch in ID needs a result from the ALU instruction now in EX
- br_dep_load  input  1  branch in ID needs a result from the load now in EX
- branch_taken  input  1  branch in ID resolved taken (operands valid)
- md_start  input  1  mult/div in EX this cycle (not a bubble)
- md_use  input  1  instruction in ID is mfhi/mflo/mthi/mtlo/mult/div
- cnt_clr  input  1  synchronous clear of both counters
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF/ID register enable
- if_flush  output  1  zero IF/ID on next edge
- id_ex_bubble  output  1  load control-zero into ID/EX on next edge
- md_busy  output  1  HI/LO not yet valid
- md_err  output  1  sticky: md_start seen while md_busy
- stall_cnt  output  CNT_W  cycles with id_ex_bubble=1, saturating
- flush_cnt  output  CNT_W  cycles with if_flush=1, saturating

## Operation
- FSM states: RUN, HOLD1.
- stall_req = ld_use | br_dep_alu | br_dep_load | (md_use & md_busy).
- RUN, stall_req=1: pc_write=0, if_id_write=0, id_ex_bubble=1, if_flush=0. A branch_taken asserted in the same cycle is ignored.
- RUN, br_dep_load=1: next state HOLD1.
- RUN, stall_req=0: pc_write=1, if_id_write=1, id_ex_bubble=0, if_flush=branch_taken.
- HOLD1: unconditional stall, with the same outputs as a stall in RUN. All hazard inputs and branch_taken are ignored. Next state RUN.
- Mult/div counter md_cnt (8 bits):
  - md_start loads MD_LATENCY-1.
  - Otherwise decrements while nonzero.
  - md_busy = (md_cnt != 0).
- md_start while md_busy: counter reloads and md_err sets. md_err is cleared only by reset.
- Counters:
  - +1 per cycle for the corresponding output; they hold at all-ones.
  - cnt_clr takes priority over increment in the same cycle.

## Timing
- Control outputs are combinational from state and inputs in the same cycle (zero latency). md_busy and the counters are registered.
- Reset (rst_n=0 at an edge): state=RUN, md_cnt=0, md_err=0, stall_cnt=0, flush_cnt=0.
- While rst_n=0, outputs are forced to pc_write=1, if_id_write=1, if_flush=0, id_ex_bubble=0, md_busy=0.
- Reset asserted in HOLD1 or during a busy mult/div abandons the operation. There is no residual stall after release.
- Branch after load: one RUN stall cycle plus one HOLD1 cycle = exactly 2 bubbles. The branch resolves in the third cycle.
- md_start at edge t: md_busy=1 for cycles t+1 .. t+MD_LATENCY-1.
  - md_use during those cycles stalls.
  - At cycle t+MD_LATENCY it proceeds.
- Counter at all-ones with the event present: holds. With cnt_clr: goes to 0.

## Structure
- Shared header pipeline_defs.vh: state encodings (RUN=1'b0, HOLD1=1'b1) and the MD_CNT_W=8 constant. Include it and do not redefine these values locally.
- Sub-module sat_counter (params W; ports clk, rst_n, clr, inc, q), instantiated twice for stall_cnt and flush_cnt.
- Top-level FSM, md counter and output logic: roughly 150-200 lines.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with ld_use=1 -> pc_write=1, id_ex_bubble=0. After release: counters are 0 and md_busy=0.
- Load-use: ld_use=1 for 1 cycle -> exactly one cycle of pc_write=0/if_id_write=0/id_ex_bubble=1, stall_cnt=1.
- Branch after load: br_dep_load=1 for 1 cycle, then all hazards 0 and branch_taken=1 ->
  - 2 stall cycles, with branch_taken ignored in HOLD1.
  - Then if_flush=1 for 1 cycle.
  - stall_cnt=2, flush_cnt=1.
- Mult/div: MD_LATENCY=4, md_start pulse, then md_use=1 held ->
  - 3 stall cycles, then pc_write=1.
  - A second md_start during busy sets md_err=1.
- Simultaneous: br_dep_alu=1 with branch_taken=1 -> stall, if_flush=0.
- Saturation: CNT_W=3, hold ld_use for 10 cycles -> stall_cnt=7. With cnt_clr=1 and ld_use=1 in the same cycle -> 0.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller.
//   state_e  : controller FSM state encoding (RUN=1'b0, HOLD1=1'b1)
//   MD_CNT_W : width of the mult/div occupancy counter
package pipeline_stall_controller_pkg;

  localparam int MD_CNT_W = 8;

  typedef enum logic {
    RUN   = 1'b0,
    HOLD1 = 1'b1
  } state_e;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (clears q)
//   clr   : synchronous clear, wins over inc
//   inc   : count this cycle
//   q     : count value, holds at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal flow; stalls for one cycle whenever any hazard is raised
// HOLD1 | second bubble of a branch-after-load; forced stall, back to RUN
//
// Ports:
//   clk, rst_n     : clock and synchronous active-low reset
//   ld_use         : load-use hazard between ID/EX and IF/ID
//   br_dep_alu     : branch in ID depends on ALU result in EX
//   br_dep_load    : branch in ID depends on load in EX (two-bubble stall)
//   branch_taken   : branch in ID resolved taken
//   md_start       : mult/div issued in EX this cycle
//   md_use         : instruction in ID touches HI/LO or the md unit
//   cnt_clr        : clear both performance counters
//   pc_write       : PC update enable
//   if_id_write    : IF/ID register enable
//   if_flush       : zero IF/ID on next edge
//   id_ex_bubble   : insert control-zero into ID/EX on next edge
//   md_busy        : HI/LO result not yet valid
//   md_err         : sticky, md_start seen while md_busy
//   stall_cnt      : saturating count of bubble cycles
//   flush_cnt      : saturating count of flush cycles
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_use,
  input  logic             br_dep_alu,
  input  logic             br_dep_load,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             md_use,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_flush,
  output logic             id_ex_bubble,
  output logic             md_busy,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);

  state_e              state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                md_err_q, md_err_d;
  logic                stall_req;

  // Gated with rst_n so the interlock is released while reset is held,
  // even before the first reset edge has cleared the counter.
  assign md_busy   = rst_n & (md_cnt_q != '0);
  assign stall_req = ld_use | br_dep_alu | br_dep_load | (md_use & md_busy);

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_flush     = 1'b0;
    id_ex_bubble = 1'b0;
    if (rst_n) begin
      case (state_q)
        RUN: begin
          if (stall_req) begin
            // A taken branch is not acted on while its operands are stale.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (br_dep_load) begin
              state_d = HOLD1;
            end
          end else begin
            if_flush = branch_taken;
          end
        end
        HOLD1: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          state_d      = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Occupancy down-counter: a new issue always reloads, even mid-operation.
  always_comb begin
    md_cnt_d = md_cnt_q;
    md_err_d = md_err_q;
    if (md_start) begin
      md_cnt_d = MD_LOAD;
      if (md_busy) begin
        md_err_d = 1'b1;
      end
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      md_err_q <= md_err_d;
    end
  end

  assign md_err = md_err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (id_ex_bubble),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (if_flush),
    .q     (flush_cnt)
  );

endmodule
